// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults and receiver state encoding
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer that resets to the idle-high level
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] ff;
    always_ff @(posedge clk) ff <= reset ? 2'b11 : {ff[0], d};
    assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with OVERSAMPLE-tick mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    state_t               state, state_next;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 mid_half, mid_bit, stop_hit;

    sync_2ff u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));

    assign mid_half = b_tick && tick_cnt == HALF;
    assign mid_bit  = b_tick && tick_cnt == LAST;
    assign stop_hit = state == STOP && mid_bit;

    always_ff @(posedge clk) state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = rx_s ? IDLE : START;
            START:   state_next = mid_half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_next = (mid_bit && bit_cnt == BLAST) ? STOP : DATA;
            STOP:    state_next = mid_bit ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    always_comb rx_busy = state != IDLE;

    // tick_cnt is held at zero in IDLE so a tick coincident with the start edge is not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= stop_hit && rx_s;
            frame_err <= stop_hit && !rx_s;
            if (stop_hit && rx_s) rx_data <= shreg;
            if (state == IDLE) tick_cnt <= '0;
            else if (b_tick) tick_cnt <= ((state == START) ? mid_half : mid_bit) ? '0 : tick_cnt + 1'b1;
            if (state == START) bit_cnt <= '0;
            else if (state == DATA && mid_bit) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= (bit_cnt == BLAST) ? bit_cnt : bit_cnt + 1'b1;
            end
        end
    end
endmodule
